quad_counter_fsm: RTL and testbench

//  Parametrised quadrature decoder plus position counter.
//  It synchronises a 2-bit A/B phase input and classifies each phase transition as HOLD, UP, DOWN or ERROR.
//  It drives an internal up/down position counter with selectable wrap or saturate arithmetic.
//  It reports a one-cycle error pulse, a sticky error flag and a saturating error count.

---
 rtl/quad_counter_fsm_pkg.sv | 37 +++
 rtl/quad_counter_fsm_sync.sv | 31 +++
 rtl/quad_counter_fsm.sv | 120 ++++++++++++
 tb/tb_quad_counter_fsm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/quad_counter_fsm_pkg.sv
// Shared quadrature decode types: phase-transition classes, Gray order and the decode function.
package rc_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    ERROR = 2'd3
  } quad_state_t;

  // Forward Gray order on {B,A}: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  function automatic logic [1:0] gray_next(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      GRAY_S0: n = GRAY_S1;
      GRAY_S1: n = GRAY_S2;
      GRAY_S2: n = GRAY_S3;
      default: n = GRAY_S0;
    endcase
    return n;
  endfunction

  function automatic quad_state_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    quad_state_t s;
    if (cur == prev)                 s = HOLD;
    else if (cur == gray_next(prev)) s = UP;
    else if (prev == gray_next(cur)) s = DOWN;
    else                             s = ERROR;
    return s;
  endfunction

endpackage

// File: rtl/quad_counter_fsm_sync.sv
// Generic resettable flop-chain synchroniser; o_q lags i_d by STAGES edges.
module quad_sync #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] w_d;
      if (gi == 0) begin : g_first
        assign w_d = i_d;
      end else begin : g_rest
        assign w_d = r_stage[gi-1];
      end
      always_ff @(posedge clk) begin
        if (rst) r_stage[gi] <= '0;
        else     r_stage[gi] <= w_d;
      end
    end
  endgenerate

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/quad_counter_fsm.sv
// Quadrature decoder with up/down position counter (wrap or saturate) and error tracking.
module quad_counter_fsm
  import rc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SAT_MODE    = 0,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          quad_ctl,
  input  logic                cnt_load,
  input  logic [CNT_W-1:0]    cnt_load_val,
  input  logic                err_clr,
  output logic                enable,
  output logic                up_down,
  output logic                error,
  output logic                err_sticky,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [CNT_W-1:0]    count,
  output quad_state_t         state
);

  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [ERRCNT_W-1:0] ERR_ONE = ERRCNT_W'(1);

  logic [1:0]          w_sync_phase;
  logic [1:0]          r_prev_phase;
  logic                r_prime;
  logic [CNT_W-1:0]    r_count,     w_count_next;
  logic [ERRCNT_W-1:0] r_err_count, w_err_count_next;
  logic                r_enable,    w_enable_next;
  logic                r_up_down,   w_up_down_next;
  logic                r_error,     w_error_next;
  logic                r_err_sticky, w_err_sticky_next;
  quad_state_t         r_state,     w_state_next;
  quad_state_t         w_dec;

  quad_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (quad_ctl),
    .o_q (w_sync_phase)
  );

  always_comb begin
    w_dec             = quad_decode(r_prev_phase, w_sync_phase);
    w_state_next      = HOLD;
    w_enable_next     = 1'b0;
    w_up_down_next    = r_up_down;
    w_error_next      = 1'b0;
    w_count_next      = r_count;
    w_err_sticky_next = r_err_sticky;
    w_err_count_next  = r_err_count;

    // Clear first so a coincident error still leaves one recorded event
    if (err_clr) begin
      w_err_sticky_next = 1'b0;
      w_err_count_next  = '0;
    end

    if (!r_prime) begin
      w_state_next = w_dec;
      case (w_dec)
        UP: begin
          w_enable_next  = 1'b1;
          w_up_down_next = 1'b1;
          if (!(SAT_MODE != 0 && r_count == '1)) w_count_next = r_count + CNT_ONE;
        end
        DOWN: begin
          w_enable_next  = 1'b1;
          w_up_down_next = 1'b0;
          if (!(SAT_MODE != 0 && r_count == '0)) w_count_next = r_count - CNT_ONE;
        end
        ERROR: begin
          w_error_next      = 1'b1;
          w_err_sticky_next = 1'b1;
          if (w_err_count_next != '1) w_err_count_next = w_err_count_next + ERR_ONE;
        end
        default: ;
      endcase
    end

    if (cnt_load) w_count_next = cnt_load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prime      <= 1'b1;
      r_prev_phase <= '0;
      r_count      <= '0;
      r_err_count  <= '0;
      r_enable     <= 1'b0;
      r_up_down    <= 1'b0;
      r_error      <= 1'b0;
      r_err_sticky <= 1'b0;
      r_state      <= HOLD;
    end else begin
      r_prime      <= 1'b0;
      r_prev_phase <= w_sync_phase;
      r_count      <= w_count_next;
      r_err_count  <= w_err_count_next;
      r_enable     <= w_enable_next;
      r_up_down    <= w_up_down_next;
      r_error      <= w_error_next;
      r_err_sticky <= w_err_sticky_next;
      r_state      <= w_state_next;
    end
  end

  assign enable     = r_enable;
  assign up_down    = r_up_down;
  assign error      = r_error;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;
  assign count      = r_count;
  assign state      = r_state;

endmodule

// File: tb/tb_quad_counter_fsm.sv
// Directed bench: wrapping and saturating instances share stimulus; expected values are hand-derived.
module tb_quad_counter_fsm;
  import rc_pkg::*;

  localparam int CNT_W = 16;
  localparam int ERRCNT_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          quad_ctl;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                err_clr;

  logic                enable, up_down, error, err_sticky;
  logic [ERRCNT_W-1:0] err_count;
  logic [CNT_W-1:0]    count;
  quad_state_t         state;

  logic                s_enable, s_up_down, s_error, s_err_sticky;
  logic [ERRCNT_W-1:0] s_err_count;
  logic [CNT_W-1:0]    s_count;
  quad_state_t         s_state;

  int checks = 0;
  int errors = 0;
  int en_cnt, err_pulses, s_en_cnt;
  logic last_ud;

  always #5 clk = ~clk;

  quad_counter_fsm #(.CNT_W(CNT_W), .SYNC_STAGES(2), .SAT_MODE(0), .ERRCNT_W(ERRCNT_W)) dut (
    .clk(clk), .rst(rst), .quad_ctl(quad_ctl), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .err_clr(err_clr),
    .enable(enable), .up_down(up_down), .error(error), .err_sticky(err_sticky),
    .err_count(err_count), .count(count), .state(state)
  );

  quad_counter_fsm #(.CNT_W(CNT_W), .SYNC_STAGES(2), .SAT_MODE(1), .ERRCNT_W(ERRCNT_W)) dut_sat (
    .clk(clk), .rst(rst), .quad_ctl(quad_ctl), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .err_clr(err_clr),
    .enable(s_enable), .up_down(s_up_down), .error(s_error), .err_sticky(s_err_sticky),
    .err_count(s_err_count), .count(s_count), .state(s_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) $display("check %s ok value=0x%0h", tag, obs);
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      en_cnt     += int'(enable);
      err_pulses += int'(error);
      s_en_cnt   += int'(s_enable);
      if (enable) last_ud = up_down;
    end
  endtask

  task automatic clr_stats();
    en_cnt = 0; err_pulses = 0; s_en_cnt = 0; last_ud = 1'bx;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; quad_ctl = 2'b00; cnt_load = 1'b0; cnt_load_val = '0; err_clr = 1'b0;
    clr_stats();
    tick(2);
    check("rst_count", 32'(count), 32'h0);
    check("rst_state", 32'(state), 32'(HOLD));
    check("rst_flags", {28'b0, enable, up_down, error, err_sticky}, 32'h0);
    check("rst_errcnt", 32'(err_count), 32'h0);
    check("rst_sat_all", {s_count, s_err_count, 2'(s_state), s_enable, s_up_down, s_error, s_err_sticky}, 32'h0);

    // 1: forward Gray sequence
    rst = 1'b0;
    clr_stats();
    tick(1);
    quad_ctl = 2'b01; tick(4);
    quad_ctl = 2'b11; tick(4);
    quad_ctl = 2'b10; tick(4);
    quad_ctl = 2'b00; tick(4);
    tick(3);
    check("fwd_count", 32'(count), 32'd4);
    check("fwd_pulses", 32'(en_cnt), 32'd4);
    check("fwd_updown", 32'(last_ud), 32'd1);
    check("fwd_no_error", 32'(err_pulses), 32'd0);
    check("fwd_state_hold", 32'(state), 32'(HOLD));

    // 2: reverse sequence from 0 wraps below zero
    cnt_load = 1'b1; cnt_load_val = 16'h0000; tick(1); cnt_load = 1'b0;
    check("load_zero", 32'(count), 32'h0);
    clr_stats();
    quad_ctl = 2'b10; tick(4);
    quad_ctl = 2'b11; tick(4);
    quad_ctl = 2'b01; tick(4);
    quad_ctl = 2'b00; tick(4);
    tick(3);
    check("rev_count_wrap", 32'(count), 32'hFFFC);
    check("rev_pulses", 32'(en_cnt), 32'd4);
    check("rev_updown", 32'(last_ud), 32'd0);
    check("rev_sat_floor", 32'(s_count), 32'h0);

    // 3: saturation at the top, and wrap of the other instance
    cnt_load = 1'b1; cnt_load_val = 16'hFFFF; tick(1); cnt_load = 1'b0;
    clr_stats();
    quad_ctl = 2'b01; tick(4);
    quad_ctl = 2'b11; tick(4);
    tick(3);
    check("sat_top_count", 32'(s_count), 32'hFFFF);
    check("sat_top_pulses", 32'(s_en_cnt), 32'd2);
    check("sat_top_updown", 32'(s_up_down), 32'd1);
    check("wrap_top_count", 32'(count), 32'h0001);
    cnt_load = 1'b1; cnt_load_val = 16'h0000; tick(1); cnt_load = 1'b0;
    clr_stats();
    quad_ctl = 2'b01; tick(7);
    check("sat_bot_count", 32'(s_count), 32'h0);
    check("sat_bot_pulses", 32'(s_en_cnt), 32'd1);
    check("sat_bot_updown", 32'(s_up_down), 32'd0);
    check("wrap_bot_count", 32'(count), 32'hFFFF);

    // 4: illegal jump, recovery, error counter saturation
    quad_ctl = 2'b00; tick(7);
    check("pre_jump_count", 32'(count), 32'hFFFE);
    clr_stats();
    quad_ctl = 2'b11; tick(7);
    check("jump_pulses", 32'(err_pulses), 32'd1);
    check("jump_no_step", 32'(en_cnt), 32'd0);
    check("jump_sticky", 32'(err_sticky), 32'd1);
    check("jump_errcnt", 32'(err_count), 32'd1);
    check("jump_count_hold", 32'(count), 32'hFFFE);
    clr_stats();
    quad_ctl = 2'b10; tick(7);
    check("recover_count", 32'(count), 32'hFFFF);
    check("recover_dir", {en_cnt[30:0], last_ud}, {31'd1, 1'b1});
    clr_stats();
    for (int i = 0; i < 260; i++) begin
      quad_ctl = quad_ctl ^ 2'b11;
      tick(1);
    end
    tick(3);
    check("errcnt_pulses", 32'(err_pulses), 32'd260);
    check("errcnt_saturate", 32'(err_count), 32'hFF);
    check("errcnt_sticky", 32'(err_sticky), 32'd1);
    check("errcnt_count_hold", 32'(count), 32'hFFFF);

    // 5: load beats a coincident step; error beats a coincident clear
    quad_ctl = 2'b00; tick(2);
    cnt_load = 1'b1; cnt_load_val = 16'h1234; tick(1); cnt_load = 1'b0;
    check("load_vs_step_count", 32'(count), 32'h1234);
    check("load_vs_step_enable", 32'(enable), 32'd1);
    check("load_vs_step_state", 32'(state), 32'(UP));
    tick(4);
    quad_ctl = 2'b01; tick(7);
    check("post_load_step", 32'(count), 32'h1235);
    quad_ctl = 2'b10; tick(2);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("clr_vs_err_pulse", 32'(error), 32'd1);
    check("clr_vs_err_sticky", 32'(err_sticky), 32'd1);
    check("clr_vs_err_errcnt", 32'(err_count), 32'd1);
    check("clr_vs_err_state", 32'(state), 32'(ERROR));
    tick(4);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("clr_only", {err_count, 7'b0, err_sticky}, 16'h0);

    // 6: mid-stream reset re-primes
    quad_ctl = 2'b11; tick(7);
    rst = 1'b1; tick(1);
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_flags", {28'b0, enable, up_down, error, err_sticky}, 32'h0);
    check("mid_rst_errcnt", 32'(err_count), 32'h0);
    check("mid_rst_state", 32'(state), 32'(HOLD));
    rst = 1'b0; tick(1);
    check("prime_edge", {29'b0, enable, error, 1'b0}, 32'h0);
    check("prime_state", 32'(state), 32'(HOLD));
    tick(6);
    clr_stats();
    quad_ctl = 2'b10; tick(7);
    check("post_rst_step_count", 32'(count), 32'd1);
    check("post_rst_step_pulses", 32'(en_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
